// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed 5-digit seven-segment display driver.
//
// Samples the five BCD digits and the decimal-point mask once per display
// frame (so a value that changes mid-frame never tears), then lights one
// digit at a time on shared active-low segment lines. Leading-zero
// blanking is optional and follows lz_en live.
//
// Ports:
//   clk        system clock, rising edge
//   clr        synchronous active-high reset
//   x1..x5     BCD digits, x1 = ten-thousands (MSD), x5 = ones (LSD)
//   lz_en      1 = blank leading zeros
//   dp_mask    per-digit decimal point, bit 0 = ones digit, 1 = lit
//   an         anodes, active-low, an[0] = ones digit
//   seg        segments, active-low, {G,F,E,D,C,B,A}
//   dp         decimal point, active-low
//   frame_tick one-cycle pulse when the digit/dp latch loads
module seg_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] x1,
    input  logic [3:0] x2,
    input  logic [3:0] x3,
    input  logic [3:0] x4,
    input  logic [3:0] x5,
    input  logic       lz_en,
    input  logic [4:0] dp_mask,
    output logic [4:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int              CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]   SCNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] scnt;
    logic [2:0]    idx;
    // idx_d is the slot being driven onto the pins; it trails idx by one
    // cycle so the frame latch is already loaded when digit 0 is shown.
    logic [2:0]    idx_d;
    // vld keeps the pins dark on the latch cycle right after reset.
    logic          vld;
    logic [3:0]    lat_dig [5];   // index 0 = ones digit
    logic [4:0]    lat_dp;

    logic          load;
    logic          scnt_wrap;
    logic [4:0]    upper_zero;    // [k]: digit k and all above it are 0
    logic [3:0]    cur_dig;
    logic          cur_dp;
    logic          blank;
    logic [4:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;  // non-BCD code shows a dash
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        load      = (idx == 3'd0) && (scnt == '0);
        scnt_wrap = (scnt == SCNT_LAST);

        upper_zero[4] = (lat_dig[4] == 4'd0);
        upper_zero[3] = upper_zero[4] && (lat_dig[3] == 4'd0);
        upper_zero[2] = upper_zero[3] && (lat_dig[2] == 4'd0);
        upper_zero[1] = upper_zero[2] && (lat_dig[1] == 4'd0);
        upper_zero[0] = upper_zero[1] && (lat_dig[0] == 4'd0);

        cur_dig = lat_dig[0];
        cur_dp  = lat_dp[0];
        case (idx_d)
            3'd1:    begin cur_dig = lat_dig[1]; cur_dp = lat_dp[1]; end
            3'd2:    begin cur_dig = lat_dig[2]; cur_dp = lat_dp[2]; end
            3'd3:    begin cur_dig = lat_dig[3]; cur_dp = lat_dp[3]; end
            3'd4:    begin cur_dig = lat_dig[4]; cur_dp = lat_dp[4]; end
            default: begin cur_dig = lat_dig[0]; cur_dp = lat_dp[0]; end
        endcase

        // The ones digit is never blanked; a blanked slot still takes its
        // full dwell time, it just stays dark.
        blank = lz_en && (idx_d != 3'd0) && upper_zero[idx_d];

        an_nxt  = 5'b11111;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (vld && !blank) begin
            an_nxt  = ~(5'b00001 << idx_d);
            seg_nxt = decode(cur_dig);
            dp_nxt  = ~cur_dp;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            scnt       <= '0;
            idx        <= 3'd0;
            idx_d      <= 3'd0;
            vld        <= 1'b0;
            // NOTE: the digit latch is a handful of flops, not a RAM, so it
            // is cleared with everything else.
            for (int i = 0; i < 5; i++) lat_dig[i] <= 4'd0;
            lat_dp     <= 5'd0;
            an         <= 5'b11111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            if (scnt_wrap) begin
                scnt <= '0;
                idx  <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            end else begin
                scnt <= scnt + CW'(1);
            end

            if (load) begin
                lat_dig[0] <= x5;
                lat_dig[1] <= x4;
                lat_dig[2] <= x3;
                lat_dig[3] <= x2;
                lat_dig[4] <= x1;
                lat_dp     <= dp_mask;
            end

            frame_tick <= load;
            idx_d      <= idx;
            vld        <= 1'b1;
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: self-checking bench for seg_scan with SCAN_DIV = 4.
//
// The reference model works from the cycle number since reset release:
// a frame snapshot is taken every 5*SCAN_DIV cycles, and the slot shown at
// cycle k (k >= 1) is ((k-1)/SCAN_DIV) mod 5 using the most recent snapshot
// taken before cycle k. Directed scenarios from the design's intent are
// followed by randomized digit, blanking, dp and reset traffic.
module tb_seg_scan;

    localparam int SD    = 4;
    localparam int FRAME = 5 * SD;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0, x5 = '0;
    logic       lz_en = 1'b0;
    logic [4:0] dp_mask = '0;
    logic [4:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    seg_scan #(.SCAN_DIV(SD)) dut (
        .clk        (clk),
        .clr        (clr),
        .x1         (x1),
        .x2         (x2),
        .x3         (x3),
        .x4         (x4),
        .x5         (x5),
        .lz_en      (lz_en),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
    endtask

    // Seven-segment patterns, active-low {G..A}, indexed by BCD code.
    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    // Model state
    int         k = -1;           // cycles since reset release, -1 = in reset
    logic [3:0] snap_dig [5];     // index 0 = ones digit
    logic [4:0] snap_dp = '0;
    logic [4:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_tick;

    // One clock: update the model at the rising edge from the inputs the DUT
    // samples there, then compare outputs at the falling edge.
    task automatic cycle();
        logic [3:0] cur [5];
        logic [4:0] onehot;
        int         slot;
        logic       blank;
        @(posedge clk);
        cur[0] = x5; cur[1] = x4; cur[2] = x3; cur[3] = x2; cur[4] = x1;
        e_an = 5'h1F; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
        if (clr) begin
            k = -1;
            for (int i = 0; i < 5; i++) snap_dig[i] = 4'd0;
            snap_dp = '0;
        end else begin
            k++;
            e_tick = (k % FRAME == 0);
            if (k > 0) begin
                slot  = ((k - 1) / SD) % 5;
                blank = 1'b0;
                if (lz_en && slot > 0) begin
                    blank = 1'b1;
                    for (int j = slot; j < 5; j++)
                        if (snap_dig[j] != 4'd0) blank = 1'b0;
                end
                if (!blank) begin
                    onehot = 5'b00001 << slot;
                    e_an   = ~onehot;
                    e_seg  = dec_tab[snap_dig[slot]];
                    e_dp   = ~snap_dp[slot];
                end
            end
            if (e_tick) begin
                for (int i = 0; i < 5; i++) snap_dig[i] = cur[i];
                snap_dp = dp_mask;
            end
        end
        @(negedge clk);
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame_tick", 32'(frame_tick), 32'(e_tick));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_x(input logic [3:0] a, b, c, d, e);
        x1 = a; x2 = b; x3 = c; x4 = d; x5 = e;
    endtask

    function automatic logic [3:0] rnd_dig();
        if ($urandom_range(0, 2) == 0) return 4'd0;
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        @(negedge clk);

        // Reset held for 3 cycles with arbitrary inputs: dark, no tick.
        clr = 1'b1;
        set_x(rnd_dig(), rnd_dig(), rnd_dig(), rnd_dig(), rnd_dig());
        lz_en = 1'b1; dp_mask = 5'b10101;
        run(3);

        // Basic scan, then anti-tearing: x5 changes 5 -> 7 before cycle 3.
        set_x(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        lz_en = 1'b0; dp_mask = '0;
        clr = 1'b0;
        run(3);
        x5 = 4'd7;
        run(44);

        // Leading zeros: 0,0,0,4,2 with blanking on, then off; all zeros.
        clr = 1'b1; run(1);
        set_x(4'd0, 4'd0, 4'd0, 4'd4, 4'd2);
        lz_en = 1'b1;
        clr = 1'b0;
        run(41);
        lz_en = 1'b0; run(20);
        set_x(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        lz_en = 1'b1; run(40);

        // Invalid code in the hundreds slot plus its decimal point.
        clr = 1'b1; run(1);
        set_x(4'd1, 4'd2, 4'hC, 4'd4, 4'd5);
        lz_en = 1'b0; dp_mask = 5'b00100;
        clr = 1'b0;
        run(41);

        // Mid-frame reset during the idx 2 slot, then restart.
        clr = 1'b1; run(1);
        clr = 1'b0; run(10);
        clr = 1'b1; run(1);
        clr = 1'b0; run(25);

        // Randomized traffic: inputs change every cycle, occasional resets.
        for (int i = 0; i < 800; i++) begin
            set_x(rnd_dig(), rnd_dig(), rnd_dig(), rnd_dig(), rnd_dig());
            dp_mask = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
            clr = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed 5-digit seven-segment display driver that directly consumes the five BCD digits produced by the binary-to-BCD converter. It samples the digit bus once per display frame to avoid tearing, then scans one digit at a time onto shared active-low segment lines. It also applies optional leading-zero blanking and per-digit decimal points. It sits between the BCD converter and the board's seven-segment pins.

## Interface
- SCAN_DIV, 100000: clock cycles each digit is lit (1 kHz digit rate at 100 MHz); legal range ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  reset, synchronous, active-high.
- x1  in  4  BCD ten-thousands digit (most significant).
- x2  in  4  BCD thousands digit.
- x3  in  4  BCD hundreds digit.
- x4  in  4  BCD tens digit.
- x5  in  4  BCD ones digit (least significant).
- lz_en  in  1  1 = blank leading zeros.
- dp_mask  in  5  decimal point per digit; bit 0 = ones digit; 1 = lit.
- an  out  5  anodes, active-low; an[0] = ones digit, an[4] = ten-thousands.
- seg  out  7  segments, active-low, {G,F,E,D,C,B,A}.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse when the digit/dp latch loads.

## Operation
- The scan counter `scnt` counts 0..SCAN_DIV-1 and wraps.
- The digit index `idx` counts 0..4. It advances when `scnt` == SCAN_DIV-1, and wraps 4→0.
- `idx` 0 selects x5 (an[0]). `idx` 4 selects x1 (an[4]).
- Frame latch: when `idx`==0 and `scnt`==0, the block loads x1..x5 and dp_mask into internal registers and pulses frame_tick.
  - This condition also holds on the first cycle after clr is released, so the first frame uses fresh data.
  - Input changes at any other time do not affect the display until the next latch.
- lz_en is sampled live, not latched.
- Decode of latched digit d:
  - 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19, 5→0x12, 6→0x02, 7→0x78, 8→0x00, 9→0x10.
  - Codes 10..15 → 0x3F (dash, G only).
- Leading-zero blanking, lz_en=1:
  - Digit k (k = 1..4) is blanked when it and every more-significant latched digit are 0.
  - The ones digit is never blanked.
  - A blanked digit drives an all-ones, seg=0x7F, dp=1.
  - Its time slot is still consumed, so the scan period is unchanged.
- Unblanked digit:
  - an = ~(1<<idx).
  - seg = decode of that digit.
  - dp = ~latched_dp_mask[idx].
- dp on a blanked digit is suppressed.

## Timing
- an, seg, dp and frame_tick are registered outputs.
- an/seg/dp reflect the (`idx`, latch) state of the previous cycle, giving one cycle of latency.
- frame_tick is asserted in the same cycle that the latch loads.
- Reset (clr=1 at an edge): at that edge the block sets
  - `scnt`=0, `idx`=0, latched digits=0, latched dp=0;
  - an=5'b11111, seg=7'h7F, dp=1, frame_tick=0.
- Cycle numbering: cycle 0 is the first edge with clr=0.
  - Cycle 0: latch loads, frame_tick=1.
  - Cycle 1: an/seg show digit 0.
- Each digit is lit for exactly SCAN_DIV cycles. Frame period = 5·SCAN_DIV cycles.
- frame_tick fires every 5·SCAN_DIV cycles.
- Anode change and segment change occur on the same edge; there is no inter-digit dead time.
- clr mid-frame: all outputs go to their reset values at that edge. The scan restarts at `idx` 0 with a fresh latch on the first cycle after release.
- clr held high indefinitely keeps the display dark and frame_tick low.

## Test plan
- Reset: clr=1 for 3 cycles with arbitrary inputs → an=11111, seg=7F, dp=1, frame_tick=0 throughout.
- Basic scan, SCAN_DIV=4, x1..x5=1,2,3,4,5, lz_en=0, dp_mask=0 → frame_tick at cycle 0 and then every 20 cycles.
  - Cycles 1-4: an=11110, seg=0x12.
  - Cycles 5-8: an=11101, seg=0x19.
  - Cycles 9-12: 11011/0x30.
  - Cycles 13-16: 10111/0x24.
  - Cycles 17-20: 01111/0x79.
- Leading zeros, SCAN_DIV=4, x=0,0,0,4,2:
  - lz_en=1 → only an[0] (seg 0x24) and an[1] (0x19) are ever low.
  - x all 0 with lz_en=1 → only an[0] is low, with seg=0x40.
  - lz_en=0 → the three upper digits show 0x40.
- Anti-tearing: change x5 from 5 to 7 at cycle 3 → seg for an[0] stays 0x12 through the current frame. It becomes 0x78 only after the next frame_tick.
- Invalid code and dp: x3=4'hC, dp_mask=5'b00100 → the hundreds slot shows seg=0x3F, dp=0; all other slots have dp=1.
- Mid-frame reset: assert clr during the `idx`=2 slot → next cycle an=11111. After release, frame_tick fires at cycle 0 and an[0] lights at cycle 1.
